// File: rtl/fifo_pkg.sv
// Shared types and constants for the async FIFO read-side stream logic.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_SIZE = 12;

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_RUN,
    RS_FINISH
  } rd_stream_state_t;

  typedef struct packed {
    logic                      last;
    logic [FIFO_DATA_SIZE-1:0] data;
  } rd_stream_entry_t;

  // Width of a counter covering 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry in-order buffer; entry 0 is the head. Each entry is {last, data}.
module rd_skid_buf #(
  parameter int unsigned W = 13
) (
  input  logic         rclk,
  input  logic         rrst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         push_ok, pop_ok;

  always_comb begin
    push_ok = push && (cnt_q != 2'd2);
    pop_ok  = pop && (cnt_q != 2'd0);
    e0_d    = e0_q;
    e1_d    = e1_q;
    cnt_d   = cnt_q;
    case ({push_ok, pop_ok})
      2'b10: begin
        if (cnt_q == 2'd0) e0_d = push_data;
        else               e1_d = push_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      // push is only accepted below two entries, so here the head is replaced
      2'b11: e0_d = push_data;
      default: ;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = e0_q;
  assign count = cnt_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Async FIFO read-side consumer re-presenting words as a burst-framed valid/ready stream.
// Optional delivered-word counter enabled by defining FIFO_RD_STREAM_STATS_EN.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_SIZE = FIFO_DATA_SIZE,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 enable,
  input  logic                 rEmpty,
  input  logic [DATA_SIZE-1:0] rData,
  output logic                 rinc,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 m_last,
  output logic                 busy,
  output logic [15:0]          stat_words
);

  localparam int unsigned    CW       = cnt_width(BURST_LEN);
  localparam logic [CW-1:0]  CNT_LAST = CW'(BURST_LEN - 1);

  rd_stream_state_t state_q, state_d;
  logic [CW-1:0]    fetch_cnt_q, fetch_cnt_d;
  logic             fetch_last;
  logic             pop;
  logic [1:0]       buf_count;
  logic [DATA_SIZE:0] buf_head;

  always_comb begin
    fetch_last  = (fetch_cnt_q == CNT_LAST);
    rinc        = !rEmpty && (state_q != RS_IDLE) && (buf_count != 2'd2);
    fetch_cnt_d = fetch_cnt_q;
    if (rinc) fetch_cnt_d = fetch_last ? '0 : fetch_cnt_q + CW'(1);

    state_d = state_q;
    case (state_q)
      RS_IDLE:   if (enable && !rEmpty) state_d = RS_RUN;
      // post-fetch count decides, so a burst begun this very cycle still completes
      RS_RUN:    if (!enable) state_d = (fetch_cnt_d != '0) ? RS_FINISH : RS_IDLE;
      RS_FINISH: if (rinc && fetch_last) state_d = RS_IDLE;
      default:   state_d = RS_IDLE;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      state_q     <= RS_IDLE;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  rd_skid_buf #(
    .W(DATA_SIZE + 1)
  ) u_buf (
    .rclk      (rclk),
    .rrst      (rrst),
    .push      (rinc),
    .push_data ({fetch_last, rData}),
    .pop       (pop),
    .head      (buf_head),
    .count     (buf_count)
  );

  assign m_valid = (buf_count != 2'd0);
  assign pop     = m_valid && m_ready;
  assign m_data  = buf_head[DATA_SIZE-1:0];
  assign m_last  = buf_head[DATA_SIZE];
  assign busy    = (state_q != RS_IDLE) || (buf_count != 2'd0);

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [15:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (pop) stat_d = stat_q + 16'd1;
  end

  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) stat_q <= '0;
    else       stat_q <= stat_d;
  end

  assign stat_words = stat_q;
`else
  assign stat_words = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed + randomized bench: FIFO model and stream scoreboard for BURST_LEN=4 and BURST_LEN=1.
module tb_fifo_rd_stream;

  logic        rclk, rrst;
  logic        enable0, rEmpty0, rinc0, m_valid0, m_ready0, m_last0, busy0;
  logic [11:0] rData0, m_data0;
  logic [15:0] stat0;
  logic        enable1, rEmpty1, rinc1, m_valid1, m_ready1, m_last1, busy1;
  logic [11:0] rData1, m_data1;
  logic [15:0] stat1;

  fifo_rd_stream #(.DATA_SIZE(12), .BURST_LEN(4)) dut (
    .rclk(rclk), .rrst(rrst), .enable(enable0), .rEmpty(rEmpty0), .rData(rData0),
    .rinc(rinc0), .m_valid(m_valid0), .m_ready(m_ready0), .m_data(m_data0),
    .m_last(m_last0), .busy(busy0), .stat_words(stat0));

  fifo_rd_stream #(.DATA_SIZE(12), .BURST_LEN(1)) dut1 (
    .rclk(rclk), .rrst(rrst), .enable(enable1), .rEmpty(rEmpty1), .rData(rData1),
    .rinc(rinc1), .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1),
    .m_last(m_last1), .busy(busy1), .stat_words(stat1));

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  logic [11:0] f0[$], f1[$];
  logic [12:0] e0[$], e1[$];
  int checks, errors, cyc;
  int fetched0, fetched1, beats0, beats1, stat_exp0, stat_exp1, rinc_cnt0;
  int first_beat, last_beat;
  bit prev_stall0, prev_stall1;
  logic [12:0] prev_out0, prev_out1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int stat_ref(input int n);
`ifdef FIFO_RD_STREAM_STATS_EN
    return n & 32'hFFFF;
`else
    return 0;
`endif
  endfunction

  task automatic drive_fifo();
    rEmpty0 = (f0.size() == 0);
    rData0  = (f0.size() != 0) ? f0[0] : 12'h000;
    rEmpty1 = (f1.size() == 0);
    rData1  = (f1.size() != 0) ? f1[0] : 12'h000;
  endtask

  // Samples outputs before the edge, then advances the FIFO/scoreboard models after it.
  task automatic step();
    logic r0, r1;
    logic [11:0] w;
    #3;
    if (rinc0) check("rinc0_when_empty", 32'(rEmpty0), 32'd0);
    if (prev_stall0) begin
      check("hold_valid0", 32'(m_valid0), 32'd1);
      check("hold_word0", 32'({m_last0, m_data0}), 32'(prev_out0));
    end
    if (m_valid0 && m_ready0) begin
      check("sb_nonempty0", 32'(e0.size() != 0), 32'd1);
      if (e0.size() != 0) begin
        check("beat_word0", 32'({m_last0, m_data0}), 32'(e0[0]));
        void'(e0.pop_front());
      end
      beats0++; stat_exp0++;
      if (first_beat < 0) first_beat = cyc;
      last_beat = cyc;
    end
    prev_stall0 = m_valid0 && !m_ready0;
    prev_out0   = {m_last0, m_data0};

    if (rinc1) check("rinc1_when_empty", 32'(rEmpty1), 32'd0);
    if (prev_stall1) begin
      check("hold_valid1", 32'(m_valid1), 32'd1);
      check("hold_word1", 32'({m_last1, m_data1}), 32'(prev_out1));
    end
    if (m_valid1 && m_ready1) begin
      check("sb_nonempty1", 32'(e1.size() != 0), 32'd1);
      if (e1.size() != 0) begin
        check("beat_word1", 32'({m_last1, m_data1}), 32'(e1[0]));
        void'(e1.pop_front());
      end
      beats1++; stat_exp1++;
    end
    prev_stall1 = m_valid1 && !m_ready1;
    prev_out1   = {m_last1, m_data1};

    r0 = rinc0; r1 = rinc1;
    @(posedge rclk);
    #1;
    cyc++;
    if (r0 && f0.size() != 0) begin
      w = f0.pop_front();
      e0.push_back({(fetched0 % 4) == 3, w});
      fetched0++; rinc_cnt0++;
    end
    if (r1 && f1.size() != 0) begin
      w = f1.pop_front();
      e1.push_back({1'b1, w});
      fetched1++;
    end
    drive_fifo();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    fetched0 = 0; fetched1 = 0; beats0 = 0; beats1 = 0;
    stat_exp0 = 0; stat_exp1 = 0; rinc_cnt0 = 0;
    first_beat = -1; last_beat = -1;
    prev_stall0 = 0; prev_stall1 = 0; prev_out0 = '0; prev_out1 = '0;
    enable0 = 0; enable1 = 0; m_ready0 = 0; m_ready1 = 0;
    rrst = 1'b1;
    drive_fifo();
    #1 rrst = 1'b0;
    #1;
    check("rst_rinc", 32'(rinc0), 32'd0);
    check("rst_valid", 32'(m_valid0), 32'd0);
    check("rst_data", 32'(m_data0), 32'd0);
    check("rst_last", 32'(m_last0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_stat", 32'(stat0), 32'd0);
    @(posedge rclk); #1;
    rrst = 1'b1;

    // 8 preloaded words, free-flowing stream
    for (int i = 1; i <= 8; i++) f0.push_back(12'(i));
    drive_fifo();
    enable0 = 1; m_ready0 = 1;
    for (int i = 0; i < 16; i++) step();
    check("t1_beats", beats0, 8);
    check("t1_rinc_cycles", rinc_cnt0, 8);
    check("t1_back_to_back", last_beat - first_beat, 7);
    check("t1_stat", 32'(stat0), stat_ref(stat_exp0));

    // downstream stalled with 5 words queued
    m_ready0 = 0; rinc_cnt0 = 0; beats0 = 0;
    for (int i = 9; i <= 13; i++) f0.push_back(12'(i));
    drive_fifo();
    #1 check("t2_rinc_latency", 32'(rinc0), 32'd1);
    step();
    #1 check("t2_valid_latency", 32'(m_valid0), 32'd1);
    for (int i = 0; i < 7; i++) step();
    check("t2_rinc_pulses", rinc_cnt0, 2);
    check("t2_valid_held", 32'(m_valid0), 32'd1);
    check("t2_head_data", 32'(m_data0), 32'h009);
    check("t2_fifo_left", f0.size(), 3);
    m_ready0 = 1;
    for (int i = 0; i < 30 && beats0 < 5; i++) step();
    check("t2_delivered", beats0, 5);
    for (int i = 14; i <= 16; i++) f0.push_back(12'(i));
    drive_fifo();
    for (int i = 0; i < 30 && (f0.size() != 0 || e0.size() != 0); i++) step();
    check("t2_drained", f0.size() + e0.size(), 0);

    // enable dropped after the 2nd beat of a burst
    beats0 = 0;
    for (int i = 17; i <= 22; i++) f0.push_back(12'(i));
    drive_fifo();
    for (int i = 0; i < 20 && beats0 < 2; i++) step();
    enable0 = 0;
    for (int i = 0; i < 12; i++) step();
    check("t3_beats", beats0, 4);
    check("t3_fifo_left", f0.size(), 2);
    check("t3_rinc_idle", 32'(rinc0), 32'd0);
    check("t3_busy", 32'(busy0), 32'd0);
    check("t3_burst_whole", fetched0 % 4, 0);

    // FIFO runs dry mid-burst, refilled later
    enable0 = 1; beats0 = 0;
    for (int i = 0; i < 10; i++) step();
    check("t4_paused_valid", 32'(m_valid0), 32'd0);
    check("t4_paused_busy", 32'(busy0), 32'd1);
    check("t4_beats_before", beats0, 2);
    f0.push_back(12'h017); f0.push_back(12'h018);
    drive_fifo();
    for (int i = 0; i < 20 && (f0.size() != 0 || e0.size() != 0); i++) step();
    check("t4_beats_after", beats0, 4);
    check("t4_burst_whole", fetched0 % 4, 0);

    // asynchronous reset with the buffer full mid-burst
    m_ready0 = 0;
    for (int i = 25; i <= 30; i++) f0.push_back(12'(i));
    drive_fifo();
    for (int i = 0; i < 6; i++) step();
    check("t5_full_valid", 32'(m_valid0), 32'd1);
    #1 rrst = 1'b0;
    #1;
    check("t5_rst_valid", 32'(m_valid0), 32'd0);
    check("t5_rst_rinc", 32'(rinc0), 32'd0);
    check("t5_rst_busy", 32'(busy0), 32'd0);
    check("t5_rst_stat", 32'(stat0), 32'd0);
    e0.delete(); e1.delete();
    fetched0 = 0; fetched1 = 0; stat_exp0 = 0; stat_exp1 = 0;
    prev_stall0 = 0; prev_stall1 = 0;
    @(posedge rclk); #1;
    rrst = 1'b1; m_ready0 = 1; beats0 = 0;
    for (int i = 0; i < 30 && (f0.size() != 0 || e0.size() != 0); i++) step();
    check("t5_after_beats", beats0, 4);

    // BURST_LEN=1 instance with random backpressure
    enable1 = 1; beats1 = 0;
    f1.push_back(12'hA01); f1.push_back(12'hA02); f1.push_back(12'hA03);
    drive_fifo();
    for (int i = 0; i < 30; i++) begin
      m_ready1 = 1'($urandom_range(0, 1));
      step();
    end
    m_ready1 = 1;
    for (int i = 0; i < 10 && e1.size() != 0; i++) step();
    check("t6_beats", beats1, 3);

    // randomized traffic on both instances
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0 && f0.size() < 16) f0.push_back(12'($urandom));
      if ($urandom_range(0, 2) == 0 && f1.size() < 16) f1.push_back(12'($urandom));
      drive_fifo();
      m_ready0 = ($urandom_range(0, 3) != 0);
      m_ready1 = ($urandom_range(0, 3) != 0);
      enable0  = ($urandom_range(0, 7) != 0);
      step();
    end
    enable0 = 0; m_ready0 = 1; m_ready1 = 1;
    for (int i = 0; i < 60 && (busy0 || busy1 || f1.size() != 0); i++) step();
    check("rand_idle0", 32'(busy0), 32'd0);
    check("rand_burst_whole", fetched0 % 4, 0);
    check("rand_sb_empty0", e0.size(), 0);
    check("rand_drained1", f1.size() + e1.size(), 0);
    check("rand_stat0", 32'(stat0), stat_ref(stat_exp0));
    check("rand_stat1", 32'(stat1), stat_ref(stat_exp1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
